// File: rtl/cve2_bridge_pkg.sv
// Shared types and constants for the OBI to Wishbone B4 classic bridge.
package cve2_bridge_pkg;

    localparam int unsigned TimeoutCyclesDefault = 255;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } bridge_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

endpackage

// File: rtl/cve2_bus_watchdog.sv
// Saturating cycle timer that flags the last permitted cycle of a Wishbone access.
module cve2_bus_watchdog import cve2_bridge_pkg::*; #(
    parameter int unsigned TimeoutCycles = TimeoutCyclesDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned TW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TW-1:0] Last = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [TW-1:0] Max  = '1;

    logic [TW-1:0] timer_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (clear_i) begin
            timer_q <= '0;
        end else if (enable_i && timer_q != Max) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // A zero timeout disables expiry entirely; the timer still runs harmlessly.
    assign expire_o = (TimeoutCycles != 0) && enable_i && (timer_q == Last);

endmodule

// File: rtl/cve2_obi_wb_bridge.sv
// OBI data port to single Wishbone B4 classic cycles, one transaction in flight,
// with a watchdog that turns a hung bus cycle into an OBI error response.
module cve2_obi_wb_bridge import cve2_bridge_pkg::*; #(
    parameter int unsigned TimeoutCycles = TimeoutCyclesDefault
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    output logic        obi_rvalid_o,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_addr_i,
    input  logic [31:0] obi_wdata_i,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        timeout_o
);

    bridge_state_e state_q, state_d;
    obi_req_t      req_q, req_d;
    logic          cyc_q, cyc_d, we_q, we_d;
    logic          rvalid_q, rvalid_d, err_q, err_d, timeout_q, timeout_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          wd_clear, wd_enable, wd_expire;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^obi_addr_i[1:0];

    cve2_bus_watchdog #(.TimeoutCycles(TimeoutCycles)) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cyc_d     = 1'b0;
        we_d      = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = 1'b0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        obi_gnt_o = 1'b0;
        case (state_q)
            BUS: begin
                wd_enable = 1'b1;
                cyc_d     = 1'b1;
                we_d      = req_q.we;
                // Priority: err over ack, ack over the watchdog.
                if (wb_err_i || wb_ack_i || wd_expire) begin
                    state_d   = RESP;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = (wb_ack_i && !wb_err_i && !req_q.we) ? wb_dat_i : 32'h0;
                    err_d     = wb_err_i | (wd_expire & ~wb_ack_i);
                    timeout_d = wd_expire & ~wb_ack_i & ~wb_err_i;
                end
            end
            default: begin
                // IDLE and RESP both accept a new request, giving 2-cycle throughput.
                obi_gnt_o = obi_req_i;
                state_d   = IDLE;
                if (obi_req_i) begin
                    state_d  = BUS;
                    req_d    = '{we: obi_we_i, be: obi_be_i,
                                 addr: {obi_addr_i[31:2], 2'b00}, wdata: obi_wdata_i};
                    cyc_d    = 1'b1;
                    we_d     = obi_we_i;
                    wd_clear = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = req_q.be;
    assign wb_adr_o     = req_q.addr;
    assign wb_dat_o     = req_q.wdata;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign timeout_o    = timeout_q;

endmodule
